// File: rtl/bp_llr_loader.sv
// Packs the channel LLR stream into 8-sample frames in two ping-pong banks and
// hands each complete frame to the BP decoder. Optional macro: BP_LLR_SAT_EN.
//
// state  | meaning
// S_IDLE | waiting for a full bank while the decoder is idle
// S_ACK  | start issued, waiting for the decoder to raise busy
// S_RUN  | decoder busy, waiting for it to finish
module bp_llr_loader #(
    parameter int BIT  = 8,
    parameter int IN_W = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [IN_W-1:0] s_data,
    input  logic            s_last,
    output logic            frame_err,
    input  logic            dec_busy,
    output logic            dec_start,
    output logic [BIT-1:0]  LLR_1,
    output logic [BIT-1:0]  LLR_2,
    output logic [BIT-1:0]  LLR_3,
    output logic [BIT-1:0]  LLR_4,
    output logic [BIT-1:0]  LLR_5,
    output logic [BIT-1:0]  LLR_6,
    output logic [BIT-1:0]  LLR_7,
    output logic [BIT-1:0]  LLR_8
);

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_RUN} state_t;

    state_t         state_q, state_d;
    logic [BIT-1:0] bank [2][8];
    logic [BIT-1:0] llr_q [8];
    logic [1:0]     full;
    logic           wb, rb;
    logic [2:0]     idx;
    logic [BIT-1:0] conv;
    logic           accept, at_end, frame_done, misalign, issue;

`ifdef BP_LLR_SAT_EN
    // Symmetric clamp so the most negative code never reaches the decoder
    localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'((2 ** (BIT - 1)) - 1);
    localparam logic signed [IN_W-1:0] SAT_MIN = -SAT_MAX;

    always_comb begin
        conv = s_data[BIT-1:0];
        if ($signed(s_data) > SAT_MAX)
            conv = SAT_MAX[BIT-1:0];
        else if ($signed(s_data) < SAT_MIN)
            conv = SAT_MIN[BIT-1:0];
    end
`else
    logic unused_hi;

    assign conv      = s_data[BIT-1:0];
    assign unused_hi = ^s_data[IN_W-1:BIT];
`endif

    assign s_ready    = !full[wb];
    assign accept     = s_valid && s_ready;
    assign at_end     = (idx == 3'd7);
    assign frame_done = accept && at_end && s_last;
    assign misalign   = accept && (at_end != s_last);

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (full[rb] && !dec_busy) begin
                    issue   = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (dec_busy)
                    state_d = S_RUN;
            end
            S_RUN: begin
                if (!dec_busy)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (accept)
            bank[wb][idx] <= conv;
    end

    // Completion and release can only target different banks, since a bank
    // being written is never full and the released bank always is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full      <= 2'b00;
            wb        <= 1'b0;
            rb        <= 1'b0;
            idx       <= 3'd0;
            frame_err <= 1'b0;
            dec_start <= 1'b0;
        end else begin
            frame_err <= misalign;
            dec_start <= issue;
            for (int i = 0; i < 2; i++) begin
                if (frame_done && wb == 1'(i))
                    full[i] <= 1'b1;
                else if (issue && rb == 1'(i))
                    full[i] <= 1'b0;
            end
            if (frame_done) begin
                wb  <= ~wb;
                idx <= 3'd0;
            end else if (misalign) begin
                idx <= 3'd0;
            end else if (accept) begin
                idx <= idx + 3'd1;
            end
            if (issue)
                rb <= ~rb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++)
                llr_q[k] <= '0;
        end else if (issue) begin
            for (int k = 0; k < 8; k++)
                llr_q[k] <= bank[rb][k];
        end
    end

    assign LLR_1 = llr_q[0];
    assign LLR_2 = llr_q[1];
    assign LLR_3 = llr_q[2];
    assign LLR_4 = llr_q[3];
    assign LLR_5 = llr_q[4];
    assign LLR_6 = llr_q[5];
    assign LLR_7 = llr_q[6];
    assign LLR_8 = llr_q[7];

endmodule

// File: tb/tb_bp_llr_loader.sv
// Directed bench for bp_llr_loader: conversion vector table plus multi-cycle
// sequences for back-pressure, misalignment, ACK hold and mid-frame reset.
module tb_bp_llr_loader;
    localparam int BIT  = 8;
    localparam int IN_W = 12;

    typedef struct {
        logic [IN_W-1:0] data;
        logic [BIT-1:0]  exp;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [IN_W-1:0] s_data = '0;
    logic            s_last = 1'b0;
    logic            frame_err;
    logic            dec_busy;
    logic            dec_start;
    logic [BIT-1:0]  LLR_1, LLR_2, LLR_3, LLR_4, LLR_5, LLR_6, LLR_7, LLR_8;

    logic            force_busy = 1'b0;
    logic            auto_en = 1'b1;
    logic            model_busy;
    int              model_cnt = 0;
    int              starts = 0;
    int              err_cycles = 0;
    logic [63:0]     frames[$];
    int              n_vec = 0;
    int              n_err = 0;
    vec_t            vecs[8];
    logic [63:0]     llr_bus;

    bp_llr_loader #(.BIT(BIT), .IN_W(IN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .frame_err(frame_err), .dec_busy(dec_busy), .dec_start(dec_start),
        .LLR_1(LLR_1), .LLR_2(LLR_2), .LLR_3(LLR_3), .LLR_4(LLR_4),
        .LLR_5(LLR_5), .LLR_6(LLR_6), .LLR_7(LLR_7), .LLR_8(LLR_8)
    );

    always #5 clk = ~clk;

    assign model_busy = (model_cnt != 0);
    assign dec_busy   = force_busy | model_busy;
    assign llr_bus    = {LLR_1, LLR_2, LLR_3, LLR_4, LLR_5, LLR_6, LLR_7, LLR_8};

    // Decoder model: records every issued frame, optionally goes busy for 5 cycles
    always @(negedge clk) begin
        if (dec_start) begin
            frames.push_back(llr_bus);
            starts <= starts + 1;
        end
        if (frame_err)
            err_cycles <= err_cycles + 1;
        if (dec_start && auto_en)
            model_cnt <= 5;
        else if (model_cnt != 0)
            model_cnt <= model_cnt - 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IN_W-1:0] d, input logic last);
        int guard = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 100)
            check("ready_timeout", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [IN_W-1:0] base);
        for (int k = 0; k < 8; k++)
            send(base + 12'(k), k == 7);
    endtask

    task automatic wait_starts(input int target);
        int guard = 0;
        while (starts < target && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("start_count", 64'(starts), 64'(target));
    endtask

    function automatic logic [63:0] ramp(input logic [7:0] base);
        logic [63:0] e;
        for (int b = 0; b < 8; b++)
            e[63-8*b -: 8] = base + 8'(b);
        return e;
    endfunction

    initial begin
        int          s0;
        int          e0;
        logic [63:0] f;

`ifdef BP_LLR_SAT_EN
        vecs[0] = '{12'h400, 8'h7F}; vecs[1] = '{12'hC00, 8'h81};
        vecs[2] = '{12'h005, 8'h05}; vecs[3] = '{12'hF80, 8'h81};
        vecs[4] = '{12'h7FF, 8'h7F}; vecs[5] = '{12'h801, 8'h81};
        vecs[6] = '{12'h07F, 8'h7F}; vecs[7] = '{12'hFFF, 8'hFF};
`else
        vecs[0] = '{12'h400, 8'h00}; vecs[1] = '{12'hC00, 8'h00};
        vecs[2] = '{12'h005, 8'h05}; vecs[3] = '{12'hF80, 8'h80};
        vecs[4] = '{12'h7FF, 8'hFF}; vecs[5] = '{12'h801, 8'h01};
        vecs[6] = '{12'h07F, 8'h7F}; vecs[7] = '{12'hFFF, 8'hFF};
`endif

        #22;
        check("rst_llr", llr_bus, 64'd0);
        check("rst_start", 64'(dec_start), 64'd0);
        check("rst_err", 64'(frame_err), 64'd0);
        check("rst_ready", 64'(s_ready), 64'd1);
        rst_n = 1'b1;
        cycles(2);

        // Basic frame 1..8 and start latency
        for (int k = 0; k < 8; k++)
            send(12'(k + 1), k == 7);
        @(negedge clk);
        check("start_early", 64'(dec_start), 64'd0);
        @(negedge clk);
        check("start_e1", 64'(dec_start), 64'd1);
        check("frame_1to8", llr_bus, 64'h0102030405060708);
        @(negedge clk);
        check("start_width", 64'(dec_start), 64'd0);
        cycles(10);
        check("basic_starts", 64'(starts), 64'd1);
        check("basic_no_err", 64'(err_cycles), 64'd0);

        // Conversion vector table
        s0 = starts;
        for (int i = 0; i < 8; i++)
            send(vecs[i].data, i == 7);
        wait_starts(s0 + 1);
        f = frames[s0];
        for (int k = 0; k < 8; k++)
            check("conv_vec", 64'(f[63-8*k -: 8]), 64'(vecs[k].exp));
        check("llr_hold", llr_bus, f);
        cycles(10);

        // Back-pressure: three frames while the decoder is held busy
        s0 = starts;
        force_busy = 1'b1;
        cycles(2);
        send_frame(12'h010);
        for (int k = 0; k < 7; k++)
            send(12'h020 + 12'(k), 1'b0);
        check("bp_ready_before16", 64'(s_ready), 64'd1);
        send(12'h027, 1'b1);
        check("bp_ready_low", 64'(s_ready), 64'd0);
        cycles(3);
        check("bp_ready_still_low", 64'(s_ready), 64'd0);
        check("bp_no_issue", 64'(starts), 64'(s0));
        force_busy = 1'b0;
        send_frame(12'h030);
        wait_starts(s0 + 3);
        check("bp_frame_a", frames[s0], ramp(8'h10));
        check("bp_frame_b", frames[s0 + 1], ramp(8'h20));
        check("bp_frame_c", frames[s0 + 2], ramp(8'h30));
        cycles(10);

        // Misaligned frame: s_last on sample 5
        s0 = starts;
        e0 = err_cycles;
        for (int k = 0; k < 5; k++)
            send(12'h040 + 12'(k), k == 4);
        check("err_pulse", 64'(frame_err), 64'd1);
        cycles(3);
        check("err_one_cycle", 64'(err_cycles - e0), 64'd1);
        check("err_no_start", 64'(starts), 64'(s0));
        send_frame(12'h050);
        wait_starts(s0 + 1);
        check("err_next_frame", frames[s0], ramp(8'h50));
        check("err_clean", 64'(err_cycles - e0), 64'd1);
        cycles(10);

        // ACK hold: decoder never acknowledges
        auto_en = 1'b0;
        s0 = starts;
        send_frame(12'h060);
        wait_starts(s0 + 1);
        send_frame(12'h070);
        cycles(10);
        check("ack_hold", 64'(starts), 64'(s0 + 1));
        force_busy = 1'b1;
        cycles(2);
        force_busy = 1'b0;
        wait_starts(s0 + 2);
        check("ack_release_frame", frames[s0 + 1], ramp(8'h70));

        // Mid-frame reset with a full frame also pending
        send_frame(12'h0A0);
        for (int k = 0; k < 4; k++)
            send(12'h0B0 + 12'(k), 1'b0);
        cycles(2);
        check("pre_reset_starts", 64'(starts), 64'(s0 + 2));
        rst_n = 1'b0;
        #3;
        check("mid_rst_llr", llr_bus, 64'd0);
        check("mid_rst_start", 64'(dec_start), 64'd0);
        check("mid_rst_err", 64'(frame_err), 64'd0);
        check("mid_rst_ready", 64'(s_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(10);
        check("post_rst_no_start", 64'(starts), 64'(s0 + 2));
        check("post_rst_llr", llr_bus, 64'd0);
        check("post_rst_ready", 64'(s_ready), 64'd1);
        auto_en = 1'b1;
        send_frame(12'h021);
        wait_starts(s0 + 3);
        check("post_rst_frame", frames[s0 + 2], ramp(8'h21));
        cycles(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bp_llr_loader.md
# bp_llr_loader

Upstream LLR framing stage for the 8-bit polar BP decoder core. It accepts channel LLRs one per cycle over a valid/ready stream and packs them into 8-sample frames held in ping-pong banks. When the decoder is idle, it presents a frame on `LLR_1..LLR_8` and pulses the decoder's `start`, so the next frame can load while the current one is decoded.

## Interface
- `BIT`, 8, decoder LLR width (two's complement).
- `IN_W`, 12, input sample width (two's complement, `IN_W >= BIT`).

- `clk`  in  1  clock. One clock; reset is asynchronous and active-low.
- `rst_n`  in  1  async active-low reset.
- `s_valid`  in  1  input sample valid.
- `s_ready`  out  1  loader can accept a sample; `s_ready = !full[wb]` (combinational).
- `s_data`  in  IN_W  channel LLR sample.
- `s_last`  in  1  marks the 8th sample of a frame.
- `frame_err`  out  1  one-cycle pulse when a frame is dropped for `s_last` misalignment.
- `dec_busy`  in  1  decoder `en_busy`.
- `dec_start`  out  1  one-cycle start pulse to the decoder.
- `LLR_1` .. `LLR_8`  out  BIT each  registered frame presented to the decoder. `LLR_1` is the first sample received.

## Operation
- Storage:
  - Two banks, each 8 x BIT.
  - Per-bank `full` flag.
  - Write bank pointer `wb` and 3-bit write index `idx`.
  - Read bank pointer `rb`.
- Write side: a sample is accepted when `s_valid && s_ready`. The converted sample is written to `bank[wb][idx]`.
  - `idx < 7` and `s_last = 0`: `idx` increments.
  - `idx = 7` and `s_last = 1`: `full[wb]` is set, `wb` toggles, `idx` returns to 0.
  - Misaligned frame (`s_last = 1` with `idx < 7`, or `s_last = 0` with `idx = 7`): the partial frame is discarded, `idx` returns to 0, `wb` is unchanged, and `frame_err` pulses on the next cycle.
- Issue FSM, 3 states:
  - IDLE: if `full[rb]` and `!dec_busy`, then at the clock edge:
    - `LLR_k` loads from `bank[rb][k-1]`;
    - `dec_start` is set to 1;
    - `full[rb]` is cleared and `rb` toggles;
    - the FSM goes to ACK.
  - ACK: `dec_start` is cleared at the first edge in ACK. The FSM stays in ACK until `dec_busy = 1`, then goes to RUN.
  - RUN: the FSM waits for `dec_busy = 0`, then goes to IDLE.
- `LLR_1..8` hold their value from one issue to the next. The decoder samples them on the edge that ends the `dec_start` cycle.
- Simultaneous write completion and read release on different banks are both honoured in the same cycle.
- When both banks are full, `s_ready = 0` until the issue that frees `rb`. `s_ready` then rises in the cycle after that edge.
- Reset mid-frame: all partial and full frames are lost, and no start is issued.

## Timing
- Reset values:
  - `dec_start = 0`, `frame_err = 0`, `LLR_1..8 = 0`;
  - FSM in IDLE;
  - `wb = rb = 0`, `idx = 0`, both `full = 0`;
  - hence `s_ready = 1`.
- Latency: the 8th sample is accepted at edge E. If the FSM is in IDLE and `dec_busy = 0`, `dec_start` and the new `LLR_*` are registered at E+1, and `dec_start` is high for exactly one cycle.
- `dec_busy` is expected at the edge after `dec_start`. ACK waits indefinitely for it, so no second start can be issued before the decoder acknowledges.
- Back-to-back frames: the second frame can complete while the first is decoding. It issues at the edge after `dec_busy` falls, via the RUN→IDLE transition plus one cycle.
- Throughput: 1 sample per cycle while a bank is free.

## Configuration
- `BP_LLR_SAT_EN` defined: inputs are saturated symmetrically to [-(2^(BIT-1)-1), +(2^(BIT-1)-1)], i.e. ±127 for BIT=8. -128 is never produced.
- `BP_LLR_SAT_EN` undefined: the loader takes `s_data[BIT-1:0]` directly (wrap, no clamp).

## Test plan
- Reset, then stream 8 samples 1..8 (`s_last` on the 8th) with `dec_busy = 0` → `dec_start` pulses one cycle at E+1 with `LLR_1..8 = 1..8`, and `frame_err` stays 0.
- With `BP_LLR_SAT_EN`, IN_W=12, samples 12'h400, 12'hC00, 12'h005, 12'hF80 → `LLR` = 8'h7F, 8'h81, 8'h05, 8'h81. Without the macro → 8'h00, 8'h00, 8'h05, 8'h80.
- Hold `dec_busy = 1` and stream 3 frames continuously → `s_ready` falls after 16 accepts. On release the frames issue in arrival order, one `dec_start` per busy cycle, with no samples lost.
- `s_last` on sample 5 → `frame_err` one pulse, no `dec_start`. The next clean 8-sample frame issues normally with its own values.
- Hold `dec_busy = 0` after `dec_start` → the FSM stays in ACK and no further `dec_start` is issued even with a full bank pending. Raise then drop `dec_busy` → the pending frame issues.
- Assert `rst_n = 0` mid-frame (after 4 samples), then release → all outputs are 0 and `s_ready = 1`. The next 8 samples form a fresh frame.
